mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: whole clock cycles allowed for the combinational multiplier to settle; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each: requester N presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each: unsigned multiplicand and multiplier for requester N.
REQ-006 SHALL have ports req0_ready and req1_ready, output, 1 each: operand pair of requester N accepted this cycle when high with reqN_valid.
REQ-007 SHALL have ports rsp0_valid and rsp1_valid, output, 1 each: product for requester N available.
REQ-008 SHALL have ports rsp0_ready and rsp1_ready, input, 1 each: requester N consumes its product.
REQ-009 SHALL have ports rsp0_prod and rsp1_prod, output, 64 each: unsigned product for requester N.
REQ-010 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-011 SHALL instantiate exactly one team 32x32 Wallace multiplier (module wallace), shared by both requesters.
REQ-012 SHALL drive the multiplier inputs only from internal operand registers op_a[31:0] and op_b[31:0], never from req ports directly.
REQ-013 SHALL implement FSM states IDLE, SETTLE and RESP, with reset state IDLE.
REQ-014 IDLE: reqN_ready SHALL be high only for the granted requester, derived combinationally from state, reqN_valid and the round-robin pointer; both ready outputs SHALL be low in SETTLE and RESP.
REQ-015 Arbitration: only one valid requester SHALL be granted; with both valid, the requester not granted most recently (pointer last_gnt) SHALL be granted.
REQ-016 On the accepting edge the block SHALL latch op_a, op_b and gnt_id, update last_gnt to gnt_id, load the settle counter with SETTLE_CYCLES and go to SETTLE.
REQ-017 SETTLE: the counter SHALL decrement every cycle; on the edge where counter==1, the multiplier output SHALL be captured into result[63:0] and the FSM SHALL go to RESP.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles; reqN_valid changes during SETTLE SHALL be ignored.
REQ-019 RESP: rspN_valid SHALL be high only for N==gnt_id; rspN_prod SHALL equal result for both N; result SHALL stay stable while rsp valid and not ready.
REQ-020 RESP with rsp ready high for gnt_id SHALL go to IDLE on that edge; no request is accepted in that same cycle.
REQ-021 Ready from the non-granted responder SHALL be ignored.
REQ-022 Latency: first RESP cycle SHALL begin exactly SETTLE_CYCLES cycles after the accepting edge.
REQ-023 Minimum accept-to-accept spacing SHALL be SETTLE_CYCLES+2 cycles.
REQ-024 Arithmetic SHALL be unsigned 32x32->64 with no truncation, so 0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE00000001.
REQ-025 Requester valid deasserted in IDLE before ready SHALL cause no state change; the spec permits withdrawal.

Reset
REQ-026 rst_n low SHALL immediately, without a clock, force state IDLE, counter 0, op_a and op_b 0, result 0, gnt_id 0 and last_gnt 1 (req0 wins the first tie).
REQ-027 During reset, all ready and rsp valid outputs and busy SHALL read 0, and rspN_prod SHALL read 0.
REQ-028 Reset asserted in SETTLE or RESP SHALL abandon the operation with no response delivered; the first request after release SHALL be arbitrated normally.

Verification
REQ-029 Scenario: SETTLE_CYCLES=2; req0 valid with a=3, b=5 -> req0_ready in the same cycle; rsp0_valid high 2 cycles after the accepting edge with rsp0_prod=15; busy=1 in between.
REQ-030 Scenario: both valid in IDLE after reset -> req0 granted first; req1 granted on the next IDLE; req0 and req1 then alternate while both stay valid.
REQ-031 Scenario: a=b=0xFFFFFFFF -> prod=0xFFFFFFFE00000001; a=0x80000000, b=2 -> prod=0x0000000100000000.
REQ-032 Scenario: rsp1_ready held low 5 cycles in RESP -> rsp1_valid and rsp1_prod stable for all 5; rsp0_ready toggling has no effect; IDLE follows only after rsp1_ready.
REQ-033 Scenario: rst_n pulsed low mid-SETTLE -> outputs zero at once, no rsp_valid afterwards; a new req1 with a=7, b=6 then returns 42.
REQ-034 Scenario: SETTLE_CYCLES=1 with back-to-back requests -> accepts spaced exactly 3 cycles apart when rsp ready is held high.

Source files
------------

// File: rtl/mul_arbiter.sv
// Two-requester front end sharing one combinational 32x32 multiplier.
// Operands are registered, given SETTLE_CYCLES to propagate, then returned on the grantee's response port.

module wallace (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_p
);
  logic [63:0] w_sum;
  logic [63:0] w_car;
  logic [63:0] w_pp;
  logic [63:0] w_t;

  // Carry-save reduction of the 32 partial products, then a single carry-propagate add.
  always_comb begin
    w_sum = '0;
    w_car = '0;
    w_pp  = '0;
    w_t   = '0;
    for (int i = 0; i < 32; i++) begin
      w_pp  = i_b[i] ? (64'(i_a) << i) : 64'd0;
      w_t   = w_sum ^ w_car ^ w_pp;
      w_car = ((w_sum & w_car) | (w_sum & w_pp) | (w_car & w_pp)) << 1;
      w_sum = w_t;
    end
    o_p = w_sum + w_car;
  end
endmodule

module mul_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_prod,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_prod,
  output logic        busy
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_op_a;
  logic [31:0]        r_op_b;
  logic [63:0]        r_result;
  logic               r_gnt_id;
  logic               r_last_gnt;
  logic               w_gnt_valid;
  logic               w_gnt_id;
  logic               w_accept;
  logic               w_capture;
  logic [63:0]        w_prod;

  wallace u_wallace (
    .i_a (r_op_a),
    .i_b (r_op_b),
    .o_p (w_prod)
  );

  // Round robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    w_gnt_valid = req0_valid | req1_valid;
    w_gnt_id    = req0_valid ? (req1_valid ? ~r_last_gnt : 1'b0) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (rst_n && w_gnt_valid) begin
          w_accept    = 1'b1;
          req0_ready  = ~w_gnt_id;
          req1_ready  = w_gnt_id;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_W'(1)) begin
          w_capture   = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        rsp0_valid = ~r_gnt_id;
        rsp1_valid = r_gnt_id;
        if (r_gnt_id ? rsp1_ready : rsp0_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand, grant and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_gnt_id   <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op_a     <= w_gnt_id ? req1_a : req0_a;
        r_op_b     <= w_gnt_id ? req1_b : req0_b;
        r_gnt_id   <= w_gnt_id;
        r_last_gnt <= w_gnt_id;
        r_cnt      <= CNT_W'(SETTLE_CYCLES);
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_capture) r_result <= w_prod;
    end
  end

  assign busy      = (r_state != IDLE);
  assign rsp0_prod = r_result;
  assign rsp1_prod = r_result;
endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: two instances (SETTLE_CYCLES 2 and 1) on shared stimulus,
// checked each cycle against a transaction-level model plus directed literal expectations.

module tb_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0v, r1v, s0r, s1r;
  logic [31:0] r0a, r0b, r1a, r1b;
  logic [1:0]  o_r0rdy, o_r1rdy, o_s0v, o_s1v, o_busy;
  logic [63:0] o_p0 [2];
  logic [63:0] o_p1 [2];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_arbiter #(.SETTLE_CYCLES(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(o_r0rdy[0]),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(o_r1rdy[0]),
    .rsp0_valid(o_s0v[0]), .rsp0_ready(s0r), .rsp0_prod(o_p0[0]),
    .rsp1_valid(o_s1v[0]), .rsp1_ready(s1r), .rsp1_prod(o_p1[0]),
    .busy(o_busy[0]));

  mul_arbiter #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(o_r0rdy[1]),
    .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(o_r1rdy[1]),
    .rsp0_valid(o_s0v[1]), .rsp0_ready(s0r), .rsp0_prod(o_p0[1]),
    .rsp1_valid(o_s1v[1]), .rsp1_ready(s1r), .rsp1_prod(o_p1[1]),
    .busy(o_busy[1]));

  function automatic int sc(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic int grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 0 : 1;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Model: an operation is pending from its accept edge; the response window opens
  // once SETTLE_CYCLES edges have passed, and closes on the grantee's response handshake.
  bit          m_pend [2];
  int          m_cyc  [2];
  bit          m_gnt  [2];
  bit          m_last [2];
  logic [63:0] m_prod [2];
  logic [63:0] m_res  [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pend[k] <= 1'b0;
        m_cyc[k]  <= 0;
        m_gnt[k]  <= 1'b0;
        m_last[k] <= 1'b1;
        m_prod[k] <= '0;
        m_res[k]  <= '0;
      end else if (!m_pend[k]) begin
        if (grant(r0v, r1v, m_last[k]) >= 0) begin
          m_pend[k] <= 1'b1;
          m_cyc[k]  <= 1;
          m_gnt[k]  <= (grant(r0v, r1v, m_last[k]) == 1);
          m_last[k] <= (grant(r0v, r1v, m_last[k]) == 1);
          m_prod[k] <= (grant(r0v, r1v, m_last[k]) == 1) ? 64'(r1a) * 64'(r1b)
                                                         : 64'(r0a) * 64'(r0b);
        end
      end else begin
        m_cyc[k] <= m_cyc[k] + 1;
        if (m_cyc[k] == sc(k)) m_res[k] <= m_prod[k];
        if (m_cyc[k] > sc(k) && (m_gnt[k] ? s1r : s0r)) m_pend[k] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check64($sformatf("u%0d req0_ready", k), 64'(o_r0rdy[k]),
              64'(rst_n && !m_pend[k] && grant(r0v, r1v, m_last[k]) == 0));
      check64($sformatf("u%0d req1_ready", k), 64'(o_r1rdy[k]),
              64'(rst_n && !m_pend[k] && grant(r0v, r1v, m_last[k]) == 1));
      check64($sformatf("u%0d rsp0_valid", k), 64'(o_s0v[k]),
              64'(m_pend[k] && m_cyc[k] > sc(k) && !m_gnt[k]));
      check64($sformatf("u%0d rsp1_valid", k), 64'(o_s1v[k]),
              64'(m_pend[k] && m_cyc[k] > sc(k) && m_gnt[k]));
      check64($sformatf("u%0d busy", k), 64'(o_busy[k]), 64'(m_pend[k]));
      check64($sformatf("u%0d rsp0_prod", k), o_p0[k], m_res[k]);
      check64($sformatf("u%0d rsp1_prod", k), o_p1[k], m_res[k]);
    end
  end

  task automatic do_op(input bit n, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] prod, output int lat);
    int bud;
    if (n) begin r1v = 1'b1; r1a = a; r1b = b; end
    else   begin r0v = 1'b1; r0a = a; r0b = b; end
    bud = 0;
    @(negedge clk);
    while (!(n ? o_r1rdy[0] : o_r0rdy[0]) && bud < 20) begin
      @(negedge clk);
      bud++;
    end
    if (bud >= 20) fail_line("accept wait");
    @(posedge clk); #1;
    r0v = 1'b0;
    r1v = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!(n ? o_s1v[0] : o_s0v[0]) && lat < 30);
    if (lat >= 30) fail_line("response wait");
    prod = n ? o_p1[0] : o_p0[0];
  endtask

  task automatic collect(input int k, input int spacing);
    int prev;
    int bud;
    bit exp_g;
    prev  = -1;
    exp_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bud = 0;
      @(negedge clk);
      while (!(o_r0rdy[k] | o_r1rdy[k]) && bud < 20) begin
        @(negedge clk);
        bud++;
      end
      if (bud >= 20) fail_line($sformatf("u%0d accept %0d", k, i));
      else begin
        check64($sformatf("u%0d grant order %0d", k, i), 64'(o_r1rdy[k]), 64'(exp_g));
        if (prev >= 0)
          check64($sformatf("u%0d accept spacing %0d", k, i), 64'(cyc - prev), 64'(spacing));
        prev  = cyc;
        exp_g = ~exp_g;
      end
      @(posedge clk);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  logic [63:0] p;
  int          lat;

  initial begin
    r0v = 1'b1; r0a = 32'd3; r0b = 32'd5;
    r1v = 1'b0; r1a = '0;    r1b = '0;
    s0r = 1'b0; s1r = 1'b0;
    #12;
    check64("reset req0_ready", 64'(o_r0rdy[0]), 64'd0);
    check64("reset busy", 64'(o_busy[0]), 64'd0);
    check64("reset prod", o_p0[0], 64'd0);

    // 3*5 accepted immediately, answered two edges later.
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check64("3x5 same-cycle ready", 64'(o_r0rdy[0]), 64'd1);
    @(posedge clk); #1;
    r0v = 1'b0;
    @(negedge clk);
    check64("3x5 busy settle1", 64'(o_busy[0]), 64'd1);
    check64("3x5 no rsp settle1", 64'(o_s0v[0]), 64'd0);
    @(negedge clk);
    check64("3x5 busy settle2", 64'(o_busy[0]), 64'd1);
    check64("3x5 no rsp settle2", 64'(o_s0v[0]), 64'd0);
    @(negedge clk);
    check64("3x5 rsp0_valid", 64'(o_s0v[0]), 64'd1);
    check64("3x5 prod", o_p0[0], 64'd15);
    s0r = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check64("3x5 back to idle", 64'(o_busy[0]), 64'd0);

    // Full-width products.
    s1r = 1'b1;
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, p, lat);
    check64("max x max", p, 64'hFFFF_FFFE_0000_0001);
    check64("latency", 64'(lat), 64'd2);
    do_op(1'b0, 32'h8000_0000, 32'd2, p, lat);
    check64("2^31 x 2", p, 64'h0000_0001_0000_0000);

    // Round robin from reset, then accept spacing on each instance.
    pulse_reset();
    r0v = 1'b1; r0a = 32'd10; r0b = 32'd11;
    r1v = 1'b1; r1a = 32'd12; r1b = 32'd13;
    collect(0, 4);
    r0v = 1'b0; r1v = 1'b0;
    pulse_reset();
    r0v = 1'b1; r1v = 1'b1;
    collect(1, 3);
    r0v = 1'b0; r1v = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Stalled response: req1 held, rsp0_ready wiggles without effect.
    s0r = 1'b0; s1r = 1'b0;
    do_op(1'b1, 32'd9, 32'd9, p, lat);
    check64("9x9 prod", p, 64'd81);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      s0r = ~s0r;
      @(negedge clk);
      check64($sformatf("stall rsp1_valid %0d", i), 64'(o_s1v[0]), 64'd1);
      check64($sformatf("stall prod %0d", i), o_p1[0], 64'd81);
    end
    s1r = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check64("stall release idle", 64'(o_busy[0]), 64'd0);

    // Reset mid-settle abandons the operation.
    s0r = 1'b1;
    r1v = 1'b1; r1a = 32'd100; r1b = 32'd3;
    @(negedge clk);
    @(posedge clk); #1;
    r1v = 1'b0;
    rst_n = 1'b0;
    #1;
    check64("abort busy", 64'(o_busy[0]), 64'd0);
    check64("abort rsp1_valid", 64'(o_s1v[0]), 64'd0);
    check64("abort prod", o_p1[0], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check64($sformatf("abort no rsp %0d", i), 64'(o_s0v | o_s1v), 64'd0);
    end
    do_op(1'b1, 32'd7, 32'd6, p, lat);
    check64("7x6 after abort", p, 64'd42);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
